// File: rtl/conv_pkg.sv
// Shared constants for the convolution normalise/pack path: widths, frame geometry
// and the reciprocal shift used for constant division.
package conv_pkg;

    localparam int unsigned IN_W  = 21;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 512;
    localparam int unsigned IMG_H = 512;

    // Shift that makes ceil(2^s/d) exact for (in_w+1)-bit dividends and any d below 2^PIX_W
    function automatic int unsigned recip_shift(input int unsigned in_w);
        return in_w + 1 + PIX_W;
    endfunction

    localparam int unsigned RECIP_SHIFT = recip_shift(IN_W);

endpackage

// File: rtl/norm_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; a write when full is taken
// only alongside a read in the same cycle.
module norm_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned W     = conv_pkg::PIX_W,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic             rd_en_i,
    output logic [W-1:0]     rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_rd, do_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/conv_norm_pack.sv
// Normalises a convolution sum by DIVISOR (reciprocal multiply + shift), saturates to
// 8 bits and buffers pixels in a show-ahead FIFO. Define NORM_ROUND_EN for round-to-nearest.
module conv_norm_pack #(
    parameter int unsigned IN_W       = conv_pkg::IN_W,
    parameter int unsigned DIVISOR    = 25,
    parameter int unsigned IMG_W      = conv_pkg::IMG_W,
    parameter int unsigned IMG_H      = conv_pkg::IMG_H,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset,
    input  logic                       i_data_valid,
    input  logic [IN_W-1:0]            i_data,
    input  logic                       i_data_ready,
    output logic                       o_data_valid,
    output logic [conv_pkg::PIX_W-1:0] o_data,
    output logic                       o_fifo_afull,
    output logic                       o_overflow,
    output logic                       o_frame_done
);

    localparam int unsigned PIX_W  = conv_pkg::PIX_W;
    localparam int unsigned SHIFT  = conv_pkg::recip_shift(IN_W);
    localparam int unsigned DIV_W  = IN_W + 1;
    localparam int unsigned MUL_W  = SHIFT + 1;
    localparam int unsigned PROD_W = DIV_W + MUL_W;
    localparam int unsigned Q_W    = PROD_W - SHIFT;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned COL_W  = $clog2(IMG_W + 1);
    localparam int unsigned ROW_W  = $clog2(IMG_H + 1);

    localparam logic [MUL_W-1:0] RECIP =
        MUL_W'(((64'd1 << SHIFT) + 64'(DIVISOR) - 64'd1) / 64'(DIVISOR));
`ifdef NORM_ROUND_EN
    localparam logic [DIV_W-1:0] BIAS = DIV_W'(DIVISOR / 2);
`else
    localparam logic [DIV_W-1:0] BIAS = '0;
`endif

    logic [PROD_W-1:0] prod_d, prod_q;
    logic              s1_valid_q, s2_valid_q;
    logic [Q_W-1:0]    quot;
    logic [PIX_W-1:0]  pix_d, pix_q;
    logic [PIX_W-1:0]  fifo_head;
    logic              fifo_empty, fifo_full, handshake, frame_last;
    logic [CNT_W-1:0]  fifo_count;
    logic [COL_W-1:0]  col_d, col_q;
    logic [ROW_W-1:0]  row_d, row_q;
    logic              overflow_d, overflow_q;

    assign prod_d = PROD_W'(DIV_W'(i_data) + BIAS) * PROD_W'(RECIP);
    assign quot   = Q_W'(prod_q >> SHIFT);
    assign pix_d  = (|quot[Q_W-1:PIX_W]) ? '1 : PIX_W'(quot);

    // Stage 1 multiplies, stage 2 shifts and saturates
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            pix_q      <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= i_data_valid;
            s2_valid_q <= s1_valid_q;
            if (i_data_valid) prod_q <= prod_d;
            if (s1_valid_q)   pix_q  <= pix_d;
        end
    end

    norm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk_i     (axi_clk),
        .rst_i     (axi_reset),
        .wr_en_i   (s2_valid_q),
        .wr_data_i (pix_q),
        .rd_en_i   (handshake),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    assign o_data_valid = !fifo_empty;
    assign o_data       = fifo_empty ? '0 : fifo_head;
    assign handshake    = o_data_valid && i_data_ready;
    assign o_fifo_afull = (fifo_count >= CNT_W'(FIFO_DEPTH - 3));
    assign frame_last   = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
    assign o_frame_done = handshake && frame_last;
    assign o_overflow   = overflow_q;

    // Raster position of the next pixel to leave, plus the sticky drop flag
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        overflow_d = overflow_q | (s2_valid_q && fifo_full && !handshake);
        if (handshake) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_conv_norm_pack.sv
// Self-checking bench for conv_norm_pack against a queue-based reference model.
// Frame geometry is reduced so that whole frames fit in a short run.
module tb_conv_norm_pack;

    localparam int unsigned IN_W    = 21;
    localparam int unsigned DIVISOR = 25;
    localparam int unsigned TB_W    = 16;
    localparam int unsigned TB_H    = 8;
    localparam int          FRAME   = TB_W * TB_H;

    logic            axi_clk = 1'b0;
    logic            axi_reset;
    logic            i_data_valid;
    logic [IN_W-1:0] i_data;
    logic            i_data_ready;
    logic            o_data_valid;
    logic [7:0]      o_data;
    logic            o_fifo_afull;
    logic            o_overflow;
    logic            o_frame_done;

    int total = 0;
    int bad   = 0;
    int pix_cnt;
    int done_cnt;
    int exp_q[$];

    conv_norm_pack #(
        .IN_W       (IN_W),
        .DIVISOR    (DIVISOR),
        .IMG_W      (TB_W),
        .IMG_H      (TB_H),
        .FIFO_DEPTH (16)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset    (axi_reset),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .i_data_ready (i_data_ready),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_fifo_afull (o_fifo_afull),
        .o_overflow   (o_overflow),
        .o_frame_done (o_frame_done)
    );

    always #5 axi_clk = ~axi_clk;

    function automatic int ref_norm(input longint x);
        longint q;
`ifdef NORM_ROUND_EN
        q = (x + DIVISOR / 2) / DIVISOR;
`else
        q = x / DIVISOR;
`endif
        return (q > 255) ? 255 : int'(q);
    endfunction

    // Reset for two cycles; returns at a falling edge with reset released
    task automatic do_reset();
        @(negedge axi_clk);
        axi_reset = 1'b1; i_data_valid = 1'b0; i_data = '0; i_data_ready = 1'b0;
        repeat (2) @(negedge axi_clk);
        axi_reset = 1'b0;
        pix_cnt = 0; done_cnt = 0;
        exp_q.delete();
    endtask

    // One cycle of streaming with scoreboard and frame-pulse checks; exp_over<0 uses the model
    task automatic tick(input bit v, input int unsigned d, input bit r, input int exp_over);
        int  e;
        bit  hs;
        i_data_valid = v; i_data = IN_W'(d); i_data_ready = r;
        #1;
        hs = o_data_valid && r;
        if (hs) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL stray_pixel: got %0d want none", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== 8'(e)) begin
                    bad++; $display("FAIL pixel_value: got %0d want %0d", o_data, e);
                end
            end
        end
        total++;
        if (o_frame_done !== (hs && (pix_cnt % FRAME == FRAME - 1))) begin
            bad++; $display("FAIL frame_done: got %0b at pixel %0d", o_frame_done, pix_cnt);
        end
        if (o_frame_done) done_cnt++;
        if (hs) pix_cnt++;
        if (v) exp_q.push_back(exp_over < 0 ? ref_norm(longint'(d)) : exp_over);
        @(negedge axi_clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1'b0, 0, 1'b1, -1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
        end
        repeat (3) tick(1'b0, 0, 1'b1, -1);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total += 5;
        if (o_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", o_data_valid); end
        if (o_data !== 8'd0)       begin bad++; $display("FAIL rst_data: got %0d want 0", o_data); end
        if (o_fifo_afull !== 1'b0) begin bad++; $display("FAIL rst_afull: got %0b want 0", o_fifo_afull); end
        if (o_overflow !== 1'b0)   begin bad++; $display("FAIL rst_ovf: got %0b want 0", o_overflow); end
        if (o_frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", o_frame_done); end
        @(negedge axi_clk);
    endtask

    task automatic test_latency();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            i_data_valid = (c == 0); i_data = IN_W'(625); i_data_ready = 1'b1;
            #1;
            total++;
            if (o_data_valid !== (c == 3)) begin
                bad++; $display("FAIL latency_valid c%0d: got %0b want %0b", c, o_data_valid, c == 3);
            end
            if (c == 3) begin
                total++;
                if (o_data !== 8'd25) begin bad++; $display("FAIL latency_data: got %0d want 25", o_data); end
            end
            @(negedge axi_clk);
        end
    endtask

    task automatic test_values();
        int unsigned vals [11] = '{625, 1625625, 0, 37, 38, 2097151, 24, 25, 6374, 6375, 6399};
`ifdef NORM_ROUND_EN
        int exps [11] = '{25, 255, 0, 1, 2, 255, 1, 1, 255, 255, 255};
`else
        int exps [11] = '{25, 255, 0, 1, 1, 255, 0, 1, 254, 255, 255};
`endif
        int unsigned d;
        bit v;
        do_reset();
        for (int i = 0; i < 11; i++) tick(1'b1, vals[i], 1'b1, exps[i]);
        drain();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0:       d = $urandom_range(0, (1 << IN_W) - 1);
                1:       d = $urandom_range(1, 300) * DIVISOR + $urandom_range(0, 13) - 1;
                default: d = $urandom_range(0, 7000);
            endcase
            v = ($urandom_range(0, 3) != 0) && !o_fifo_afull;
            tick(v, d, $urandom_range(0, 1) == 1, -1);
        end
        drain();
    endtask

    task automatic test_overflow();
        int stored;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            i_data_valid = (c < 20); i_data = IN_W'(c * 25); i_data_ready = 1'b0;
            #1;
            stored = (c < 2) ? 0 : ((c - 2 > 16) ? 16 : c - 2);
            total += 2;
            if (o_fifo_afull !== (stored >= 13)) begin
                bad++; $display("FAIL afull c%0d: got %0b want %0b", c, o_fifo_afull, stored >= 13);
            end
            if (o_overflow !== (c - 2 > 16)) begin
                bad++; $display("FAIL overflow c%0d: got %0b want %0b", c, o_overflow, c - 2 > 16);
            end
            @(negedge axi_clk);
        end
        for (int j = 0; j < 17; j++) begin
            i_data_valid = 1'b0; i_data_ready = 1'b1;
            #1;
            total++;
            if (o_data_valid !== (j < 16)) begin
                bad++; $display("FAIL drain_valid %0d: got %0b want %0b", j, o_data_valid, j < 16);
            end
            if (j < 16) begin
                total++;
                if (o_data !== 8'(j)) begin bad++; $display("FAIL drain_order %0d: got %0d want %0d", j, o_data, j); end
            end
            @(negedge axi_clk);
        end
        total++;
        if (o_overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %0b want 1", o_overflow); end
    endtask

    task automatic test_frame();
        int sent = 0;
        int n    = 0;
        bit v;
        do_reset();
        for (int i = 0; i < FRAME; i++) tick(1'b1, $urandom_range(0, (1 << IN_W) - 1), 1'b1, -1);
        drain();
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL frame1_pulses: got %0d want 1", done_cnt); end
        while (sent < FRAME && n < 5000) begin
            v = ($urandom_range(0, 2) != 0) && !o_fifo_afull;
            if (v) sent++;
            tick(v, $urandom_range(0, 9000), $urandom_range(0, 3) != 0, -1);
            n++;
        end
        drain();
        total += 3;
        if (done_cnt !== 2)         begin bad++; $display("FAIL frame2_pulses: got %0d want 2", done_cnt); end
        if (pix_cnt !== 2 * FRAME)  begin bad++; $display("FAIL frame_pixels: got %0d want %0d", pix_cnt, 2 * FRAME); end
        if (o_overflow !== 1'b0)    begin bad++; $display("FAIL frame_ovf: got %0b want 0", o_overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            i_data_valid = 1'b1; i_data = IN_W'(c * 50); i_data_ready = 1'b0;
            @(negedge axi_clk);
        end
        total++;
        if (o_data_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %0b want 1", o_data_valid); end
        axi_reset = 1'b1; i_data = IN_W'(5000);
        @(negedge axi_clk);
        #1;
        total += 3;
        if (o_data_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0b want 0", o_data_valid); end
        if (o_overflow !== 1'b0)   begin bad++; $display("FAIL mid_rst_ovf: got %0b want 0", o_overflow); end
        if (o_fifo_afull !== 1'b0) begin bad++; $display("FAIL mid_rst_afull: got %0b want 0", o_fifo_afull); end
        @(negedge axi_clk);
        axi_reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i_data_valid = (c == 0); i_data = IN_W'(2500); i_data_ready = 1'b1;
            #1;
            total++;
            if (o_data_valid !== (c == 3)) begin
                bad++; $display("FAIL post_rst_valid c%0d: got %0b want %0b", c, o_data_valid, c == 3);
            end
            if (c == 3) begin
                total++;
                if (o_data !== 8'd100) begin bad++; $display("FAIL post_rst_data: got %0d want 100", o_data); end
            end
            @(negedge axi_clk);
        end
    endtask

    initial begin
        axi_reset = 1'b1; i_data_valid = 1'b0; i_data = '0; i_data_ready = 1'b0;
        test_reset();
        test_latency();
        test_values();
        test_overflow();
        test_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_norm_pack.md
CONV_NORM_PACK -- requirements
Module: conv_norm_pack

Interface
REQ-001 SHALL have parameter IN_W, default 21, which is the width of the convolution sum input.
REQ-002 SHALL have parameter DIVISOR, default 25, which is the normalisation divisor; legal range is 1..255.
REQ-003 SHALL have parameter IMG_W, default 512, which is the number of pixels per line.
REQ-004 SHALL have parameter IMG_H, default 512, which is the number of lines per frame.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, which is the output FIFO depth; it is a power of 2 and at least 8.
REQ-006 SHALL have port axi_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port axi_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_data_valid, input, 1 bit: the convolution sum is valid this cycle (no stall possible upstream).
REQ-009 SHALL have port i_data, input, IN_W bits: unsigned convolution sum.
REQ-010 SHALL have port i_data_ready, input, 1 bit: the downstream sink accepts o_data.
REQ-011 SHALL have port o_data_valid, output, 1 bit: o_data holds a pixel.
REQ-012 SHALL have port o_data, output, 8 bits: normalised, saturated pixel.
REQ-013 SHALL have port o_fifo_afull, output, 1 bit: FIFO occupancy is at least FIFO_DEPTH-3.
REQ-014 SHALL have port o_overflow, output, 1 bit: sticky; a pixel was dropped.
REQ-015 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse on the last pixel of a frame.

Function
REQ-016 SHALL compute q = floor(i_data/DIVISOR), exact for every i_data in 0..2^IN_W-1, using reciprocal multiply and shift (no iterative divider).
REQ-017 SHALL output min(q,255) (saturation).
REQ-018 SHALL pipeline the computation in 2 register stages: multiply, then shift and saturate. An input sampled at cycle N is written to the FIFO at the edge of cycle N+2 and is visible on o_data at N+3 when the FIFO was empty.
REQ-019 SHALL treat the FIFO as show-ahead: o_data_valid = !empty, and o_data equals the head entry.
REQ-020 SHALL use this transfer rule: a handshake occurs when o_data_valid && i_data_ready; o_data and o_data_valid remain stable until the handshake.
REQ-021 SHALL have no empty bypass: a write into an empty FIFO becomes visible the next cycle.
REQ-022 SHALL accept a write when full only if a read happens in the same cycle; occupancy is then unchanged.
REQ-023 SHALL drop a write when full with no read; it then sets o_overflow, which holds until reset, and FIFO contents are unchanged.
REQ-024 SHALL keep column counter 0..IMG_W-1 and row counter 0..IMG_H-1, advanced per output handshake; the column wraps into a row increment, and the row wraps to 0 at frame end.
REQ-025 SHALL pulse o_frame_done for the one cycle in which the handshake of pixel (IMG_W-1, IMG_H-1) occurs.
REQ-026 SHALL make o_fifo_afull combinational from occupancy; upstream uses it to withhold its next line.
REQ-027 SHALL ignore i_data when i_data_valid=0; such cycles produce no pipeline bubble side effects.

Reset
REQ-028 SHALL, on reset, set o_data_valid=0, o_data=0, o_fifo_afull=0, o_overflow=0, o_frame_done=0, FIFO occupancy=0, pipeline valids=0, and both counters=0.
REQ-029 SHALL, on reset mid-operation, discard in-flight and stored pixels with no partial output; normal operation resumes on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, when NORM_ROUND_EN is defined, compute q = floor((i_data + floor(DIVISOR/2))/DIVISOR), round-to-nearest, still exact and saturated.
REQ-031 SHALL, when NORM_ROUND_EN is undefined, truncate per REQ-016; latency is identical either way.

Structure
REQ-032 SHALL place IN_W, PIX_W=8, IMG_W, IMG_H, and the reciprocal shift constant in shared package conv_pkg.
REQ-033 SHALL implement the FIFO as sub-module norm_fifo (synchronous, show-ahead, occupancy output); the arithmetic pipeline and counters live in conv_norm_pack.

Verification
REQ-034 SHALL verify that with ready=1, i_data=625 at cycle 0 gives o_data=25 with o_data_valid=1 at cycle 3.
REQ-035 SHALL verify that i_data=1625625 (25*255*255) gives o_data=255, and i_data=0 gives 0.
REQ-036 SHALL verify that i_data=37 gives 1 and i_data=38 gives 1 when truncating; with NORM_ROUND_EN, 37 gives 1 and 38 gives 2.
REQ-037 SHALL verify that with ready=0 and 20 consecutive inputs 0,25,..,475: o_fifo_afull rises at 13 stored, 16 are stored, o_overflow=1, and raising ready drains 0..15 in order.
REQ-038 SHALL verify that 262144 inputs with ready=1 produce exactly one o_frame_done pulse, coincident with the final handshake, and the counters return to 0.
REQ-039 SHALL verify that reset asserted with 8 entries stored leaves o_data_valid=0 and o_overflow=0 the next cycle, and the next input appears 3 cycles after reset deasserts.
